instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of program counter and instruction address.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 en  input  1  run enable; sampled in IDLE and at EXECUTE exit only.
REQ-006 mem_req  output  1  instruction read request to memory.
REQ-007 mem_addr  output  PC_WIDTH  instruction address, equals pc while mem_req high.
REQ-008 mem_ack  input  1  memory read complete; mem_rdata valid same cycle.
REQ-009 mem_rdata  input  16  instruction word from memory.
REQ-010 OP  output  4  opcode, IR[15:12], feeds control unit OP.
REQ-011 immed  output  1  immediate-select bit, IR[11].
REQ-012 flag  output  1  flag-update bit, IR[10].
REQ-013 rd  output  2  destination register, IR[9:8].
REQ-014 operand  output  8  source register / imm8, IR[7:0].
REQ-015 instr_valid  output  1  decoded fields valid for control unit.
REQ-016 exec_done  input  1  control/datapath has finished current instruction.
REQ-017 pc_sel  input  1  branch/jump taken, from control unit.
REQ-018 branch_target  input  PC_WIDTH  next PC when pc_sel taken.
REQ-019 pc  output  PC_WIDTH  current program counter.
REQ-020 state  output  2  FSM state: IDLE=00, FETCH=01, DECODE=10, EXECUTE=11.
REQ-021 instr_count  output  16  retired-instruction counter.

Function
REQ-022 FSM SHALL have exactly four states IDLE, FETCH, DECODE, EXECUTE, encoded per REQ-020.
REQ-023 IDLE: mem_req=0, instr_valid=0; en=1 -> FETCH next cycle, else stay.
REQ-024 FETCH: mem_req=1, mem_addr=pc, held until mem_ack=1; en ignored.
REQ-025 FETCH with mem_ack=1: IR <= mem_rdata, -> DECODE; mem_req low from DECODE onward.
REQ-026 Minimum fetch latency SHALL be one cycle (ack in first FETCH cycle); no timeout, wait unbounded.
REQ-027 DECODE: single cycle, instr_valid=1, -> EXECUTE unconditionally.
REQ-028 EXECUTE: instr_valid=1, wait for exec_done=1.
REQ-029 EXECUTE with exec_done=1: pc <= branch_target if pc_sel=1, else pc <= pc+1 modulo 2^PC_WIDTH.
REQ-030 EXECUTE exit: en=1 -> FETCH, en=0 -> IDLE; instr_count <= instr_count+1 modulo 2^16.
REQ-031 OP/immed/flag/rd/operand SHALL be driven combinationally from IR at all times; IR changes only per REQ-025 or reset.
REQ-032 mem_ack outside FETCH SHALL be ignored (no IR or state change).
REQ-033 pc_sel and branch_target SHALL be ignored except in EXECUTE with exec_done=1.
REQ-034 exec_done outside EXECUTE SHALL be ignored.
REQ-035 pc at all-ones with sequential advance SHALL wrap to 0; instr_count all-ones SHALL wrap to 0.
REQ-036 mem_addr SHALL equal pc in every state (value only meaningful while mem_req=1).

Reset
REQ-037 reset low SHALL immediately, without clk, force state=IDLE, pc=RESET_PC, IR=16'h0000, mem_req=0, instr_valid=0, instr_count=0.
REQ-038 Reset values SHALL give OP=0, immed=0, flag=0, rd=0, operand=0, mem_addr=RESET_PC.
REQ-039 Reset asserted mid-FETCH or mid-EXECUTE SHALL abandon the transaction; a late mem_ack or exec_done after release SHALL be ignored per REQ-032/034.
REQ-040 After reset release, first FETCH SHALL occur no earlier than the cycle after en=1 is sampled in IDLE.

Verification
REQ-041 Reset, en=1, mem_ack on first FETCH cycle, mem_rdata=16'h1A35 -> DECODE: OP=1, immed=1, flag=0, rd=2, operand=8'h35, instr_valid=1; mem_addr=0.
REQ-042 mem_ack delayed 5 cycles -> mem_req high and state=01 for 6 cycles, IR unchanged until ack.
REQ-043 EXECUTE, exec_done=1, pc_sel=1, branch_target=8'h40 -> pc=8'h40, next FETCH mem_addr=8'h40; pc_sel=1 with exec_done=0 -> pc unchanged.
REQ-044 pc=8'hFF, exec_done=1, pc_sel=0 -> pc=8'h00, instr_count incremented by 1.
REQ-045 reset pulled low during FETCH (mem_req=1) -> mem_req=0, state=IDLE, pc=RESET_PC same time step; mem_ack pulse after release -> no IR change.
REQ-046 en=0 at EXECUTE exit -> state IDLE, mem_req stays 0; en=1 later -> FETCH at new pc.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/sequence unit: fetches a 16-bit word at pc, presents decoded
// fields to the control unit, and advances pc when execution completes.
module instr_fetch #(
  parameter int                   PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  output logic [3:0]          OP,
  output logic                immed,
  output logic                flag,
  output logic [1:0]          rd,
  output logic [7:0]          operand,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                pc_sel,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          state,
  output logic [15:0]         instr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FETCH   = 2'b01,
    DECODE  = 2'b10,
    EXECUTE = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                fetch_done, retire;

  assign fetch_done = (state_q == FETCH) && mem_ack;
  assign retire     = (state_q == EXECUTE) && exec_done;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = FETCH;
      FETCH:   if (mem_ack) state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: if (exec_done) state_d = en ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of state so reset clears them without a clock
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH:           mem_req     = 1'b1;
      DECODE, EXECUTE: instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (fetch_done) ir_d = mem_rdata;
    if (retire) begin
      pc_d  = pc_sel ? branch_target : pc_q + PC_WIDTH'(1);
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q  <= 16'h0000;
      pc_q  <= RESET_PC;
      cnt_q <= 16'h0000;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign OP          = ir_q[15:12];
  assign immed       = ir_q[11];
  assign flag        = ir_q[10];
  assign rd          = ir_q[9:8];
  assign operand     = ir_q[7:0];
  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
